// File: rtl/vdp_vram_sched.sv
// rtl/vdp_vram_sched.sv - CPU VRAM port scheduler with display-fetch arbitration; option macro VDP_VRAM_STARVE_GUARD_EN
module vdp_vram_sched #(
  parameter int VRAM_SIZE  = 8192,
  parameter int STARVE_MAX = 64,
  localparam int AW = $clog2(VRAM_SIZE)
) (
  input  logic          pxclk,
  input  logic          reset,
  input  logic          cpu_wr_tick,
  input  logic          cpu_rd_tick,
  input  logic          cpu_mode,
  input  logic [7:0]    cpu_din,
  output logic [7:0]    cpu_dout,
  input  logic          dma_req,
  input  logic [AW-1:0] dma_addr,
  output logic          dma_grant,
  output logic          dma_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_re,
  output logic          ram_we,
  output logic [7:0]    ram_wdata,
  input  logic [7:0]    ram_rdata,
  output logic          busy,
  output logic          overrun
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PEND = 2'd1;
  localparam logic [1:0] CAPT = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] vaddr;
  logic [7:0]    lo_byte;
  logic          ff;
  logic [7:0]    rd_ahead;
  logic [7:0]    wdata;
  logic          op;       // 1 = read, 0 = write

  // A write strobe masks a coincident read strobe.
  logic wr_ev, rd_ev;
  logic addr_ld, q_rd, q_wr, req, accept, ctrl_rd, issue;

  assign wr_ev   = cpu_wr_tick;
  assign rd_ev   = cpu_rd_tick & ~cpu_wr_tick;
  assign addr_ld = wr_ev & cpu_mode & ff & ~cpu_din[7];
  assign q_rd    = (addr_ld & ~cpu_din[6]) | (rd_ev & ~cpu_mode);
  assign q_wr    = wr_ev & ~cpu_mode;
  assign req     = addr_ld | q_rd | q_wr;
  assign accept  = req & ~busy;
  assign ctrl_rd = rd_ev & cpu_mode;
  assign issue   = (state == PEND) & ~dma_grant;

  assign busy     = (state != IDLE);
  assign cpu_dout = rd_ahead;

`ifdef VDP_VRAM_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve_cnt;
  logic          force_cpu;

  assign force_cpu = (state == PEND) && (starve_cnt == CW'(STARVE_MAX));
  assign dma_grant = dma_req & ~force_cpu;

  // Count consecutive cycles a pending CPU op loses the slot; clear otherwise.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if ((state == PEND) && dma_req && !force_cpu) begin
      starve_cnt <= starve_cnt + CW'(1);
    end else begin
      starve_cnt <= '0;
    end
  end
`else
  assign dma_grant = dma_req;
`endif

  // Display fetch always wins the slot; a CPU op only drives RAM while pending.
  always_comb begin
    ram_addr  = vaddr;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_wdata = wdata;
    if (dma_grant) begin
      ram_addr = dma_addr;
      ram_re   = 1'b1;
    end else if (state == PEND) begin
      ram_re = op;
      ram_we = ~op;
    end
  end

  // Registered display-data qualifier: RAM read latency is one cycle.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) dma_valid <= 1'b0;
    else        dma_valid <= dma_grant;
  end

  // Two-byte control sequencing; any other port access resynchronises the flag.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      ff      <= 1'b0;
      lo_byte <= 8'h00;
    end else if (wr_ev && cpu_mode) begin
      if (!ff) begin
        lo_byte <= cpu_din;
        ff      <= 1'b1;
      end else begin
        ff <= 1'b0;
      end
    end else if (wr_ev || rd_ev) begin
      ff <= 1'b0;
    end
  end

  // Sticky drop indicator, cleared by a control-port read.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset)              overrun <= 1'b0;
    else if (ctrl_rd)        overrun <= 1'b0;
    else if (req && busy)    overrun <= 1'b1;
  end

  // CPU op sequencer: accept while idle, issue when the slot is free, capture reads.
  always_ff @(posedge pxclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      vaddr    <= '0;
      wdata    <= 8'h00;
      op       <= 1'b0;
      rd_ahead <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (addr_ld) vaddr <= AW'({cpu_din[5:0], lo_byte});
            if (q_wr)    wdata <= cpu_din;
            if (q_rd || q_wr) begin
              op    <= q_rd;
              state <= PEND;
            end
          end
        end
        PEND: begin
          if (issue) begin
            vaddr <= vaddr + AW'(1);
            state <= op ? CAPT : IDLE;
          end
        end
        CAPT: begin
          rd_ahead <= ram_rdata;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vdp_vram_sched.sv
// tb/tb_vdp_vram_sched.sv - scoreboard bench for vdp_vram_sched
module tb_vdp_vram_sched;

  localparam int VRAM_SIZE = 8192;
  localparam int AW = 13;

  logic          pxclk = 1'b0;
  logic          reset;
  logic          cpu_wr_tick, cpu_rd_tick, cpu_mode;
  logic [7:0]    cpu_din, cpu_dout;
  logic          dma_req, dma_grant, dma_valid;
  logic [AW-1:0] dma_addr, ram_addr;
  logic          ram_re, ram_we;
  logic [7:0]    ram_wdata, ram_rdata;
  logic          busy, overrun;

  logic          pre_we;
  logic [AW-1:0] pre_addr;
  logic [7:0]    pre_data;
  logic [7:0]    mem [0:VRAM_SIZE-1];

  typedef struct {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ent_t;

  ent_t exp_wr[$];
  ent_t exp_rd[$];

  int n_checks = 0;
  int n_errors = 0;
  int rd_pend_cnt = 0;
  logic [7:0] rd_pend_data;

  vdp_vram_sched #(.VRAM_SIZE(VRAM_SIZE), .STARVE_MAX(8)) dut (
    .pxclk(pxclk), .reset(reset),
    .cpu_wr_tick(cpu_wr_tick), .cpu_rd_tick(cpu_rd_tick), .cpu_mode(cpu_mode),
    .cpu_din(cpu_din), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_grant(dma_grant), .dma_valid(dma_valid),
    .ram_addr(ram_addr), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .busy(busy), .overrun(overrun)
  );

  always #5 pxclk = ~pxclk;

  // Single-port VRAM model with a one-cycle read latency and a bench preload port.
  always @(posedge pxclk) begin
    if (pre_we)      mem[pre_addr] <= pre_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re)      ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pxclk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge pxclk);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    cyc(1);
    pre_we = 1'b0;
  endtask

  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d);
    ent_t e;
    e.a = a; e.d = d;
    exp_wr.push_back(e);
  endtask

  task automatic push_rd(input logic [AW-1:0] a, input logic [7:0] d);
    ent_t e;
    e.a = a; e.d = d;
    exp_rd.push_back(e);
  endtask

  task automatic ctrl_wr(input logic [7:0] d);
    cpu_mode = 1'b1; cpu_din = d; cpu_wr_tick = 1'b1;
    cyc(1);
    cpu_wr_tick = 1'b0;
  endtask

  task automatic ctrl_rd();
    cpu_mode = 1'b1; cpu_rd_tick = 1'b1;
    cyc(1);
    cpu_rd_tick = 1'b0;
  endtask

  task automatic data_wr(input logic [7:0] d);
    cpu_mode = 1'b0; cpu_din = d; cpu_wr_tick = 1'b1;
    cyc(1);
    cpu_wr_tick = 1'b0;
  endtask

  task automatic data_rd();
    cpu_mode = 1'b0; cpu_rd_tick = 1'b1;
    cyc(1);
    cpu_rd_tick = 1'b0;
  endtask

  // Monitor: pops expected CPU RAM accesses and checks read-ahead data two cycles after issue.
  initial begin
    ent_t e;
    forever begin
      @(negedge pxclk);
      if (rd_pend_cnt > 0) begin
        rd_pend_cnt--;
        if (rd_pend_cnt == 0) chk("rd_ahead_data", cpu_dout, rd_pend_data);
      end
      if (reset && !dma_grant && ram_we) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_wr_addr", ram_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_addr", ram_addr, e.a);
          chk("wr_data", ram_wdata, e.d);
        end
      end
      if (reset && !dma_grant && ram_re) begin
        if (exp_rd.size() == 0) begin
          chk("unexpected_rd_addr", ram_addr, 32'hFFFF_FFFF);
        end else begin
          e = exp_rd.pop_front();
          chk("rd_addr", ram_addr, e.a);
          rd_pend_data = e.d;
          rd_pend_cnt  = 2;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; cpu_wr_tick = 1'b0; cpu_rd_tick = 1'b0; cpu_mode = 1'b0;
    cpu_din = 8'h00; dma_req = 1'b1; dma_addr = 13'h100; pre_we = 1'b0;
    pre_addr = '0; pre_data = 8'h00;

    // Reset state, display fetch requesting
    at_neg();
    chk("rst_dma_grant", dma_grant, 1);
    chk("rst_ram_re", ram_re, 1);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_dma_valid", dma_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_cpu_dout", cpu_dout, 0);
    cyc(1);
    dma_req = 1'b0;
    preload(13'h123, 8'hA5);
    preload(13'h124, 8'h5A);
    preload(13'h125, 8'h3C);
    at_neg();
    chk("rst_dma_grant_idle", dma_grant, 0);
    chk("rst_ram_re_idle", ram_re, 0);
    cyc(1);
    reset = 1'b1;
    cyc(2);

    // Address setup with prefetch, then sequential data reads
    push_rd(13'h123, 8'hA5);
    ctrl_wr(8'h23);
    ctrl_wr(8'h01);
    cyc(2);
    chk("prefetch_dout", cpu_dout, 8'hA5);
    push_rd(13'h124, 8'h5A);
    data_rd();
    cyc(2);
    push_rd(13'h125, 8'h3C);
    data_rd();
    cyc(2);

    // Write burst at minimum spacing
    ctrl_wr(8'h00);
    ctrl_wr(8'h40);
    push_wr(13'h000, 8'h11); data_wr(8'h11); cyc(1);
    push_wr(13'h001, 8'h22); data_wr(8'h22); cyc(1);
    push_wr(13'h002, 8'h33); data_wr(8'h33); cyc(1);
    chk("burst_mem0", mem[0], 8'h11);
    chk("burst_mem1", mem[1], 8'h22);
    chk("burst_mem2", mem[2], 8'h33);
    chk("burst_overrun", overrun, 0);

    // Display fetch holds the slot for 20 cycles
    dma_req = 1'b1;
    push_wr(13'h003, 8'h44);
    data_wr(8'h44);
    for (int i = 0; i < 20; i++) begin
      at_neg();
      chk("dma_block_we", ram_we, 0);
      chk("dma_block_busy", busy, 1);
      chk("dma_block_valid", dma_valid, 1);
      cyc(1);
    end
    dma_req = 1'b0;
    at_neg();
    chk("dma_release_we", ram_we, 1);
    cyc(1);

    // Register write is ignored; simultaneous ticks resolve to the write
    ctrl_wr(8'h00);
    ctrl_wr(8'h87);
    push_wr(13'h004, 8'h99);
    cpu_mode = 1'b0; cpu_din = 8'h99; cpu_wr_tick = 1'b1; cpu_rd_tick = 1'b1;
    cyc(1);
    cpu_wr_tick = 1'b0; cpu_rd_tick = 1'b0;
    cyc(1);
    chk("regwr_overrun", overrun, 0);

    // Overrun: back-to-back writes, second dropped, cleared by control read
    push_wr(13'h005, 8'h55);
    data_wr(8'h55);
    data_wr(8'h66);
    at_neg();
    chk("overrun_set", overrun, 1);
    cyc(1);
    ctrl_rd();
    at_neg();
    chk("overrun_clr", overrun, 0);
    cyc(1);
    push_wr(13'h006, 8'h67);
    data_wr(8'h67);
    cyc(1);

    // Address wrap at top of VRAM, confirmed by a read at address 0
    ctrl_wr(8'hFF);
    ctrl_wr(8'h5F);
    push_wr(13'h1FFF, 8'h77);
    data_wr(8'h77);
    cyc(1);
    chk("wrap_mem", mem[VRAM_SIZE-1], 8'h77);
    push_rd(13'h000, 8'h11);
    data_rd();
    cyc(3);

    // Reset while a write is blocked: it must never reach RAM
    dma_req = 1'b1;
    data_wr(8'hEE);
    cyc(2);
    reset = 1'b0;
    cyc(1);
    dma_req = 1'b0;
    cyc(1);
    reset = 1'b1;
    cyc(5);
    at_neg();
    chk("midrst_busy", busy, 0);
    chk("midrst_mem0", mem[0], 8'h11);
    cyc(1);

`ifdef VDP_VRAM_STARVE_GUARD_EN
    // Forced CPU issue on the 9th blocked cycle
    dma_req = 1'b1;
    push_rd(13'h000, 8'h11);
    data_rd();
    for (int i = 1; i <= 8; i++) begin
      at_neg();
      chk("starve_grant_blocked", dma_grant, 1);
      cyc(1);
    end
    at_neg();
    chk("starve_grant_forced", dma_grant, 0);
    chk("starve_re_forced", ram_re, 1);
    cyc(1);
    at_neg();
    chk("starve_grant_after", dma_grant, 1);
    chk("starve_valid_after", dma_valid, 0);
    cyc(1);
    dma_req = 1'b0;
    cyc(3);
`endif

    cyc(5);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
